// File: rtl/exec_issue_arbiter.sv
// Issue arbiter: N_REQ ports share one execution unit through a single output slot.
// ISSUE_ARB_ROUND_ROBIN_EN selects round-robin grant, otherwise lowest index wins.
`ifndef LEN_CONTEXT
`define LEN_CONTEXT 8
`endif

module exec_issue_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LEN_CTX = `LEN_CONTEXT,
    parameter int LEN_PAY = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*LEN_CTX-1:0] req_context,
    input  logic [N_REQ*LEN_PAY-1:0] req_payload,
    output logic [N_REQ-1:0]         req_accepted,
    input  logic                     branch_hazard,
    input  logic [LEN_CTX-1:0]       hazard_context_info,
    output logic                     unit_valid,
    output logic [LEN_PAY-1:0]       unit_payload,
    output logic [LEN_CTX-1:0]       unit_context,
    input  logic                     unit_ready,
    output logic [15:0]              issue_count
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic               slot_valid_q, slot_valid_d;
    logic [LEN_PAY-1:0] slot_pay_q, slot_pay_d;
    logic [LEN_CTX-1:0] slot_ctx_q, slot_ctx_d;
    logic [15:0]        issue_count_q, issue_count_d;

    logic [N_REQ-1:0] kill_req;
    logic [N_REQ-1:0] elig;
    logic             kill_slot;
    logic             xfer;
    logic             can_load;
    logic             found;
    logic             grant;
    logic [PW-1:0]    grant_idx;

    always_comb begin
        kill_req = '0;
        elig     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            kill_req[i] = branch_hazard
                & |(hazard_context_info
                    & req_context[i*LEN_CTX +: LEN_CTX]);
            elig[i] = req_valid[i] & ~kill_req[i];
        end
    end

    assign kill_slot = slot_valid_q & branch_hazard
                     & |(hazard_context_info & slot_ctx_q);
    assign unit_valid = slot_valid_q & ~kill_slot;
    assign xfer       = unit_valid & unit_ready;
    assign can_load   = ~slot_valid_q | xfer | kill_slot;

`ifdef ISSUE_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] rr_q, rr_d;

    // Search starts at the pointer and wraps; first eligible port wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[(int'(rr_q) + k) % N_REQ]) begin
                found     = 1'b1;
                grant_idx = PW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = PW'((int'(grant_idx) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Walk downward so the lowest eligible index is the last one written.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                found     = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end
`endif

    // Gate on rstn so nothing is acknowledged while the slot is being cleared.
    assign grant = found & can_load & rstn;

    always_comb begin
        req_accepted = '0;
        if (grant) begin
            req_accepted[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        slot_valid_d  = slot_valid_q;
        slot_pay_d    = slot_pay_q;
        slot_ctx_d    = slot_ctx_q;
        issue_count_d = issue_count_q + 16'(xfer);
        if (grant) begin
            slot_valid_d = 1'b1;
            slot_pay_d   = req_payload[grant_idx*LEN_PAY +: LEN_PAY];
            slot_ctx_d   = req_context[grant_idx*LEN_CTX +: LEN_CTX];
        end else if (xfer || kill_slot) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_valid_q  <= 1'b0;
            slot_pay_q    <= '0;
            slot_ctx_q    <= '0;
            issue_count_q <= '0;
        end else begin
            slot_valid_q  <= slot_valid_d;
            slot_pay_q    <= slot_pay_d;
            slot_ctx_q    <= slot_ctx_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign unit_payload = slot_pay_q;
    assign unit_context = slot_ctx_q;
    assign issue_count  = issue_count_q;

endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Randomized plus directed bench for exec_issue_arbiter against a
// cycle-level reference model of the issue slot.
module tb_exec_issue_arbiter;
    localparam int N = 4;
    localparam int C = 8;
    localparam int P = 64;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   rv = '0;
    logic [P-1:0]   rp[N];
    logic [C-1:0]   rc[N];
    logic [N*C-1:0] rc_bus;
    logic [N*P-1:0] rp_bus;
    logic [N-1:0]   req_accepted;
    logic           bh = 1'b0;
    logic [C-1:0]   hinfo = '0;
    logic           unit_valid;
    logic [P-1:0]   unit_payload;
    logic [C-1:0]   unit_context;
    logic           ur = 1'b0;
    logic [15:0]    issue_count;

    always #5 clk = ~clk;

    always_comb begin
        rc_bus = '0;
        rp_bus = '0;
        for (int i = 0; i < N; i++) begin
            rc_bus[i*C +: C] = rc[i];
            rp_bus[i*P +: P] = rp[i];
        end
    end

    exec_issue_arbiter #(
        .N_REQ(N), .LEN_CTX(C), .LEN_PAY(P)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid(rv),
        .req_context(rc_bus),
        .req_payload(rp_bus),
        .req_accepted(req_accepted),
        .branch_hazard(bh),
        .hazard_context_info(hinfo),
        .unit_valid(unit_valid),
        .unit_payload(unit_payload),
        .unit_context(unit_context),
        .unit_ready(ur),
        .issue_count(issue_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic        m_sv;
    logic [63:0] m_pay;
    logic [7:0]  m_ctx;
    logic [15:0] m_cnt;
    int          m_rr;

    int          g_last;
    logic [3:0]  o_acc;
    logic        o_uv;
    logic [63:0] o_pay;

    function automatic logic hit(input logic [7:0] c);
        return bh && ((hinfo & c) != 0);
    endfunction

    // Check one cycle at posedge+2, then advance the model over the edge.
    task automatic cyc();
        logic ks, uv, xf, free;
        logic [3:0] acc;
        int g;
        #1;
        ks = m_sv && hit(m_ctx);
        uv = m_sv && !ks;
        xf = uv && ur;
        free = !m_sv || xf || ks;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_rr + k) % N;
                if (g < 0 && rv[p] && !hit(rc[p])) g = p;
            end
        end
        acc = (g >= 0) ? 4'(1 << g) : 4'b0;
        o_acc = req_accepted;
        o_uv = unit_valid;
        o_pay = unit_payload;
        check_eq("accepted", 64'(req_accepted), 64'(acc));
        check_eq("unit_valid", 64'(unit_valid), 64'(uv));
        if (uv) begin
            check_eq("payload", unit_payload, m_pay);
            check_eq("context", 64'(unit_context), 64'(m_ctx));
        end
        check_eq("count", 64'(issue_count), 64'(m_cnt));
        g_last = g;
        @(posedge clk);
        if (g >= 0) begin
            m_sv = 1'b1;
            m_pay = rp[g];
            m_ctx = rc[g];
`ifdef ISSUE_ARB_ROUND_ROBIN_EN
            m_rr = (g + 1) % N;
`endif
        end else if (xf || ks) begin
            m_sv = 1'b0;
        end
        if (xf) m_cnt = m_cnt + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rv = 4'hF;
        #1;
        check_eq("rst_acc", 64'(req_accepted), 64'd0);
        check_eq("rst_uv", 64'(unit_valid), 64'd0);
        check_eq("rst_cnt", 64'(issue_count), 64'd0);
        m_sv = 1'b0;
        m_pay = '0;
        m_ctx = '0;
        m_cnt = '0;
        m_rr = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rv = '0;
        bh = 1'b0;
        hinfo = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] seq[5];
    logic [15:0] cnt0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rp[i] = 64'(i);
            rc[i] = 8'h01;
        end
        do_reset();

        ur = 1'b1;
        repeat (5) begin
            cyc();
            check_eq("idle_uv", 64'(o_uv), 64'd0);
            check_eq("idle_acc", 64'(o_acc), 64'd0);
        end
        check_eq("idle_cnt", 64'(issue_count), 64'd0);

        rv = 4'b0001;
        rp[0] = 64'h1234;
        rc[0] = 8'h01;
        cyc();
        check_eq("t2_acc", 64'(o_acc), 64'd1);
        rv = '0;
        cyc();
        check_eq("t2_uv", 64'(o_uv), 64'd1);
        check_eq("t2_pay", o_pay, 64'h1234);
        check_eq("t2_cnt", 64'(issue_count), 64'd1);

        do_reset();
`ifdef ISSUE_ARB_ROUND_ROBIN_EN
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int i = 0; i < N; i++) rp[i] = 64'h100 + 64'(i);
        rv = 4'b1111;
        ur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("t3_grant", 64'(o_acc), 64'(seq[i]));
        end

        ur = 1'b0;
        rv = 4'b0010;
        rp[1] = 64'hBEEF;
        cyc();
        check_eq("t4_stall", 64'(o_acc), 64'd0);
        check_eq("t4_full", 64'(o_uv), 64'd1);
        ur = 1'b1;
        cyc();
        check_eq("t4_acc", 64'(o_acc), 64'b0010);
        rv = '0;
        cyc();
        check_eq("t4_pay", o_pay, 64'hBEEF);

        do_reset();
        ur = 1'b0;
        rv = 4'b0001;
        rc[0] = 8'h04;
        rp[0] = 64'hA;
        cyc();
        rv = 4'b0110;
        rc[1] = 8'h04;
        rc[2] = 8'h01;
        rp[2] = 64'hC;
        bh = 1'b1;
        hinfo = 8'h04;
        ur = 1'b1;
        cnt0 = issue_count;
        cyc();
        check_eq("t5_uv", 64'(o_uv), 64'd0);
        check_eq("t5_acc", 64'(o_acc), 64'b0100);
        check_eq("t5_cnt", 64'(issue_count), 64'(cnt0));
        bh = 1'b0;
        rv = '0;
        cyc();
        check_eq("t5_pay", o_pay, 64'hC);
        ur = 1'b0;
        rv = 4'b0001;
        cyc();
        rv = '0;
        bh = 1'b1;
        ur = 1'b1;
        cnt0 = issue_count;
        cyc();
        check_eq("t5_kill", 64'(o_uv), 64'd0);
        bh = 1'b0;
        cyc();
        check_eq("t5_empty", 64'(o_uv), 64'd0);
        check_eq("t5_cnt2", 64'(issue_count), 64'(cnt0));

        do_reset();
        for (int t = 0; t < 3000; t++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (g_last == i || (rv[i] && hit(rc[i]))) rv[i] = 1'b0;
                if (!rv[i] && ($urandom % 2 == 0)) begin
                    rv[i] = 1'b1;
                    rp[i] = {$urandom, $urandom};
                    rc[i] = 8'(1 << ($urandom % 8));
                end
            end
            bh = ($urandom % 6 == 0);
            hinfo = 8'(1 << ($urandom % 8)) | 8'(1 << ($urandom % 8));
            ur = ($urandom % 4 != 0);
        end

        do_reset();
        rv = 4'b0001;
        rc[0] = 8'h01;
        ur = 1'b1;
        repeat (65537) cyc();
        check_eq("wrap", 64'(issue_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
